fetch_pc_sequencer: RTL

//  Controller for the fetch stage: owns the fetch PC and sequences instruction-memory requests.

---
 rtl/fetch_pc_sequencer_if.sv | 36 +++
 rtl/fetch_pc_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-stage bundle: decode handshake, execute redirect, BTB lookup and the
// instruction-memory request/response channel, all grouped around one sequencer.
interface fetch_pc_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
) ();
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  btb_hit;
  logic [ADDR_WIDTH-1:0] btb_predicted_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  fetch_valid;
  logic [INST_WIDTH-1:0] fetch_inst;
  logic                  fetch_pred_taken;
  logic [ADDR_WIDTH-1:0] fetch_pred_pc;

  // Sequencer side.
  modport master (
    input  stall, redirect_valid, redirect_pc, btb_hit, btb_predicted_pc,
    input  imem_gnt, imem_rsp_valid, imem_rdata,
    output pc, imem_req, imem_addr, fetch_valid, fetch_inst, fetch_pred_taken, fetch_pred_pc
  );

  // Environment side: decode, execute, BTB and instruction memory.
  modport slave (
    output stall, redirect_valid, redirect_pc, btb_hit, btb_predicted_pc,
    output imem_gnt, imem_rsp_valid, imem_rdata,
    input  pc, imem_req, imem_addr, fetch_valid, fetch_inst, fetch_pred_taken, fetch_pred_pc
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage controller: owns the fetch PC, issues one instruction-memory request
// at a time, discards responses made stale by a redirect and buffers one
// instruction while decode is stalled.
// Optional macro BTB_PREDICT_EN: when defined the BTB steers the next PC; when
// undefined the BTB inputs are ignored and the next PC is always pc+4.
module fetch_pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           INST_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  fetch_pc_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StBoot, StReq, StWait, StHold, StDrop} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] pred_next;
  logic                  pred_taken;
  logic                  req;
  logic                  granted;
  logic                  valid_raw;
  logic                  fetch_valid;
  logic                  accept;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

`ifdef BTB_PREDICT_EN
  assign pred_taken = bus.btb_hit;
  assign pred_next  = bus.btb_hit ? bus.btb_predicted_pc : pc_plus4;
`else
  logic unused_btb;
  assign unused_btb = ^{bus.btb_hit, bus.btb_predicted_pc};
  assign pred_taken = 1'b0;
  assign pred_next  = pc_plus4;
`endif

  assign req     = (state_q == StReq) && !bus.stall;
  assign granted = req && bus.imem_gnt;

  // A response in WAIT is handed straight to decode only if decode can take it;
  // otherwise it is parked in the HOLD buffer.
  assign valid_raw   = ((state_q == StWait) && bus.imem_rsp_valid && !bus.stall) ||
                       (state_q == StHold);
  assign fetch_valid = valid_raw && !bus.redirect_valid;
  assign accept      = fetch_valid && !bus.stall;

  assign bus.pc               = pc_q;
  assign bus.imem_req         = req;
  assign bus.imem_addr        = pc_q;
  assign bus.fetch_valid      = fetch_valid;
  assign bus.fetch_inst       = ((state_q == StWait) && bus.imem_rsp_valid) ? bus.imem_rdata
                                                                            : inst_q;
  assign bus.fetch_pred_taken = fetch_valid && pred_taken;
  assign bus.fetch_pred_pc    = fetch_valid ? pred_next : '0;

  // Next-state: redirect overrides everything, otherwise walk the fetch handshake.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      unique case (state_q)
        // A response arriving with the redirect retires the outstanding request.
        StWait:  state_d = bus.imem_rsp_valid ? StReq : StDrop;
        StReq:   state_d = granted ? StDrop : StReq;
        StDrop:  state_d = bus.imem_rsp_valid ? StReq : StDrop;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StBoot: state_d = StReq;
        StReq:  if (granted) state_d = StWait;
        StWait: begin
          if (bus.imem_rsp_valid) begin
            if (bus.stall) begin
              inst_d  = bus.imem_rdata;
              state_d = StHold;
            end else begin
              state_d = StReq;
            end
          end
        end
        StHold: if (!bus.stall) state_d = StReq;
        StDrop: if (bus.imem_rsp_valid) state_d = StReq;
        default: state_d = StBoot;
      endcase
      if (accept) pc_d = pred_next;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

endmodule
